// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO over an internal DEPTH x DATA_W array, all outputs registered.
// Define FIFO_STICKY_ERR_EN to make over_flow/under_flow sticky until err_clr.
module fifo_ram_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned AF_LVL = (2 ** ADDR_W) - 2,
    parameter int unsigned AE_LVL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_sig,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_sig,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full_sig,
    output logic              empty_sig,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              over_flow,
    output logic              under_flow
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wrt_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_rej;
    logic              rd_rej;

    // Acceptance looks only at registered flags, never at the opposite request.
    always_comb begin
        wr_acc     = wrt_sig & ~full_sig;
        rd_acc     = rd_sig & ~empty_sig;
        wr_rej     = wrt_sig & full_sig;
        rd_rej     = rd_sig & empty_sig;
        count_next = count;
        if (wr_acc && !rd_acc)
            count_next = count + 1'b1;
        else if (rd_acc && !wr_acc)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wrt_ptr[ADDR_W-1:0]] <= din;
    end

`ifndef FIFO_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt_ptr      <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full_sig     <= 1'b0;
            empty_sig    <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            dout         <= '0;
            rd_valid     <= 1'b0;
            over_flow    <= 1'b0;
            under_flow   <= 1'b0;
        end else begin
            if (wr_acc)
                wrt_ptr <= wrt_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr[ADDR_W-1:0]];
            end
            rd_valid     <= rd_acc;
            count        <= count_next;
            full_sig     <= (count_next == DEPTH_C);
            empty_sig    <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
`ifdef FIFO_STICKY_ERR_EN
            over_flow    <= wr_rej | (over_flow & ~err_clr);
            under_flow   <= rd_rej | (under_flow & ~err_clr);
`else
            over_flow    <= wr_rej;
            under_flow   <= rd_rej;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl (DEPTH=4) against a queue-based reference model.
// Honours FIFO_STICKY_ERR_EN the same way the design does.
module tb_fifo_ram_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wrt_sig = 1'b0;
    logic [7:0] din = '0;
    logic       rd_sig = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] dout;
    logic       rd_valid;
    logic [2:0] count;
    logic       full_sig, empty_sig, almost_full, almost_empty, over_flow, under_flow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] exp_dout = '0;
    bit         exp_valid = 0;
    bit         exp_ovf = 0;
    bit         exp_udf = 0;

    fifo_ram_ctrl #(.DATA_W(8), .ADDR_W(2), .AF_LVL(2), .AE_LVL(1)) dut (
        .clk(clk), .rst_n(rst_n), .wrt_sig(wrt_sig), .din(din), .rd_sig(rd_sig),
        .err_clr(err_clr), .dout(dout), .rd_valid(rd_valid), .count(count),
        .full_sig(full_sig), .empty_sig(empty_sig), .almost_full(almost_full),
        .almost_empty(almost_empty), .over_flow(over_flow), .under_flow(under_flow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model advances at the edge, outputs are sampled 1ns later.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
        bit is_full, is_empty;
        @(negedge clk);
        wrt_sig = w; din = d; rd_sig = r; err_clr = c;
        @(posedge clk);
        is_full  = (q.size() == 4);
        is_empty = (q.size() == 0);
`ifdef FIFO_STICKY_ERR_EN
        exp_ovf = (w && is_full) || (exp_ovf && !c);
        exp_udf = (r && is_empty) || (exp_udf && !c);
`else
        exp_ovf = w && is_full;
        exp_udf = r && is_empty;
`endif
        exp_valid = 0;
        if (r && !is_empty) begin
            exp_dout  = q.pop_front();
            exp_valid = 1;
        end
        if (w && !is_full) q.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wrt_sig = 0; rd_sig = 0; err_clr = 0; din = '0;
        q.delete(); exp_dout = '0; exp_valid = 0; exp_ovf = 0; exp_udf = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if ({empty_sig, almost_empty, full_sig, almost_full} !== 4'b1100) begin
            errors++; $display("FAIL reset_flags got %b exp 1100", {empty_sig, almost_empty, full_sig, almost_full}); end
        checks++; if ({dout, rd_valid, over_flow, under_flow} !== 11'd0) begin
            errors++; $display("FAIL reset_out got dout=%0h v=%b o=%b u=%b exp all 0", dout, rd_valid, over_flow, under_flow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) cycle(1, 8'hA1 + 8'(i), 0, 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
        checks++; if ({full_sig, almost_full, empty_sig} !== 3'b110) begin
            errors++; $display("FAIL fill_flags got %b exp 110", {full_sig, almost_full, empty_sig}); end
    endtask

    task automatic test_overflow();
        cycle(1, 8'hFF, 0, 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
        checks++; if (over_flow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", over_flow); end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h00, 1, 0);
            checks++; if (rd_valid !== 1'b1 || dout !== 8'hA1 + 8'(i)) begin
                errors++; $display("FAIL ovf_read%0d got v=%b d=%0h exp v=1 d=%0h", i, rd_valid, dout, 8'hA1 + 8'(i)); end
        end
        checks++; if (empty_sig !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL ovf_drain got e=%b c=%0d exp e=1 c=0", empty_sig, count); end
    endtask

    task automatic test_underflow();
        cycle(1, 8'h55, 1, 0);
        checks++; if (under_flow !== 1'b1 || rd_valid !== 1'b0 || count !== 3'd1) begin
            errors++; $display("FAIL udf_same got u=%b v=%b c=%0d exp u=1 v=0 c=1", under_flow, rd_valid, count); end
        cycle(0, 8'h00, 1, 0);
        checks++; if (rd_valid !== 1'b1 || dout !== 8'h55) begin
            errors++; $display("FAIL udf_next got v=%b d=%0h exp v=1 d=55", rd_valid, dout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent[$];
        logic [7:0] d;
        int         got = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin d = 8'($urandom); sent.push_back(d); cycle(1, d, 0, 0); end
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom); sent.push_back(d);
            cycle(1, d, 1, 0);
            checks++; if (count !== 3'd2 || rd_valid !== 1'b1 || dout !== sent[got]) begin
                errors++; $display("FAIL b2b_%0d got c=%0d v=%b d=%0h exp c=2 v=1 d=%0h", i, count, rd_valid, dout, sent[got]); end
            got++;
        end
    endtask

    task automatic test_err_flag();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 8'(i), 0, 0);
        cycle(1, 8'hEE, 0, 0);
        checks++; if (over_flow !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", over_flow); end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'h00, 0, 0);
`ifdef FIFO_STICKY_ERR_EN
            checks++; if (over_flow !== 1'b1) begin errors++; $display("FAIL err_hold%0d got %b exp 1", i, over_flow); end
`else
            checks++; if (over_flow !== 1'b0) begin errors++; $display("FAIL err_pulse%0d got %b exp 0", i, over_flow); end
`endif
        end
        cycle(0, 8'h00, 0, 1);
        checks++; if (over_flow !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", over_flow); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 8'h30 + 8'(i), 0, 0);
        cycle(0, 8'h00, 1, 0);
        checks++; if (rd_valid !== 1'b1 || dout !== 8'h30) begin
            errors++; $display("FAIL rst_pre got v=%b d=%0h exp v=1 d=30", rd_valid, dout); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || empty_sig !== 1'b1 || rd_valid !== 1'b0 || dout !== 8'h00) begin
            errors++; $display("FAIL rst_async got c=%0d e=%b v=%b d=%0h exp c=0 e=1 v=0 d=0", count, empty_sig, rd_valid, dout); end
        @(posedge clk); #1;
        checks++; if (count !== 3'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL rst_hold got c=%0d v=%b exp c=0 v=0", count, rd_valid); end
        q.delete(); exp_dout = '0; exp_valid = 0; exp_ovf = 0; exp_udf = 0;
        @(negedge clk);
        rst_n = 1'b1; rd_sig = 0;
        cycle(1, 8'h77, 0, 0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rst_first got c=%0d exp 1", count); end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            n = q.size();
            checks++; if (count !== 3'(n) || full_sig !== (n == 4) || empty_sig !== (n == 0) ||
                          almost_full !== (n >= 2) || almost_empty !== (n <= 1)) begin
                errors++; $display("FAIL rnd_occ%0d got c=%0d f=%b e=%b af=%b ae=%b exp c=%0d", i, count, full_sig, empty_sig, almost_full, almost_empty, n); end
            checks++; if (rd_valid !== exp_valid || dout !== exp_dout) begin
                errors++; $display("FAIL rnd_data%0d got v=%b d=%0h exp v=%b d=%0h", i, rd_valid, dout, exp_valid, exp_dout); end
            checks++; if (over_flow !== exp_ovf || under_flow !== exp_udf) begin
                errors++; $display("FAIL rnd_err%0d got o=%b u=%b exp o=%b u=%b", i, over_flow, under_flow, exp_ovf, exp_udf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_err_flag();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
